// File: rtl/pad_ctrl_pkg.sv
// Shared op encodings, FSM state type and default geometry for the pad I/O controller.
package pad_ctrl_pkg;

    localparam int unsigned DEF_WIDTH       = 14;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_TURN_CYCLES = 2;

    localparam logic [1:0] OP_WRITE_OUT = 2'd0;
    localparam logic [1:0] OP_SET_DIR   = 2'd1;
    localparam logic [1:0] OP_READ      = 2'd2;
    localparam logic [1:0] OP_CLR_CHG   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_TURN = 2'd2,
        ST_RESP = 2'd3
    } pad_state_e;

endpackage

// File: rtl/pad_sync.sv
// Vector multi-stage synchroniser for asynchronous pad inputs; synchronous active-low reset.
module pad_sync #(
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[STAGES-1];

endmodule

// File: rtl/pad_io_ctrl.sv
// Command-driven sequencer for the bidirectional pad ring: masked writes, direction changes
// with a turnaround gap, synchronised reads and sticky pin-change flags with an interrupt.
module pad_io_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned TURN_CYCLES = DEF_TURN_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_oe,
    output logic [WIDTH-1:0] chg_flags,
    output logic             chg_irq
);

    localparam int unsigned TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam int unsigned WW = $clog2(SYNC_STAGES + 2);

    pad_state_e       r_state;
    logic             r_live;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_pad_o;
    logic [WIDTH-1:0] r_pad_oe;
    logic [WIDTH-1:0] r_en_set;
    logic [TW-1:0]    r_turn_cnt;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [WIDTH-1:0] r_chg;
    logic             r_irq;
    logic [WIDTH-1:0] r_prev;
    logic [WW-1:0]    r_warm;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_pad_o_nxt;
    logic [WIDTH-1:0] w_rel_oe;
    logic [WIDTH-1:0] w_en_set;
    logic [WIDTH-1:0] w_chg_set;
    logic [WIDTH-1:0] w_chg_clr;
    logic             w_accept;
    logic             w_exec;

    pad_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_i),
        .q     (w_sync)
    );

    // r_live keeps cmd_ready low through reset and for the cycle of release.
    assign cmd_ready   = r_live & (r_state == ST_IDLE);
    assign w_accept    = cmd_valid & cmd_ready;
    assign w_exec      = (r_state == ST_EXEC);
    assign w_pad_o_nxt = (r_pad_o & ~r_mask) | (r_data & r_mask);
    assign w_rel_oe    = r_pad_oe & ~(r_mask & ~r_data);
    assign w_en_set    = r_mask & r_data & ~r_pad_oe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_live      <= 1'b0;
            r_op        <= OP_WRITE_OUT;
            r_mask      <= '0;
            r_data      <= '0;
            r_pad_o     <= '0;
            r_pad_oe    <= '0;
            r_en_set    <= '0;
            r_turn_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_live      <= 1'b1;
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= cmd_op;
                        r_mask  <= cmd_mask;
                        r_data  <= cmd_data;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    case (r_op)
                        OP_WRITE_OUT: begin
                            r_pad_o    <= w_pad_o_nxt;
                            r_rsp_data <= w_pad_o_nxt;
                        end
                        OP_SET_DIR: begin
                            // Releases land now; new drivers wait out the turnaround.
                            r_pad_oe <= w_rel_oe;
                            if (w_en_set == '0) begin
                                r_rsp_data <= w_rel_oe;
                            end else begin
                                r_en_set    <= w_en_set;
                                r_turn_cnt  <= TW'(TURN_CYCLES - 1);
                                r_state     <= ST_TURN;
                                r_rsp_valid <= 1'b0;
                            end
                        end
                        OP_READ: begin
                            r_rsp_data <= w_sync;
                        end
                        default: begin
                            r_rsp_data <= r_chg;
                        end
                    endcase
                end
                ST_TURN: begin
                    if (r_turn_cnt == '0) begin
                        r_pad_oe    <= r_pad_oe | r_en_set;
                        r_rsp_data  <= r_pad_oe | r_en_set;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_turn_cnt <= r_turn_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Synchronisers start at 0, so the first SYNC_STAGES+1 edges would report false edges.
    assign w_chg_set = (r_warm == '0) ? ((w_sync ^ r_prev) & ~r_pad_oe) : '0;
    assign w_chg_clr = (w_exec && (r_op == OP_CLR_CHG)) ? r_mask : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_warm <= WW'(SYNC_STAGES + 1);
            r_chg  <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_prev <= w_sync;
            if (r_warm != '0) begin
                r_warm <= r_warm - 1'b1;
            end
            r_chg <= (r_chg & ~w_chg_clr) | w_chg_set;
            r_irq <= |r_chg;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign pad_o     = r_pad_o;
    assign pad_oe    = r_pad_oe;
    assign chg_flags = r_chg;
    assign chg_irq   = r_irq;

endmodule

// File: doc/pad_io_ctrl.md
# pad_io_ctrl

Command-driven controller that sequences the chip's 14 bidirectional pad cells (output value, output enable, input sampling). It sits between on-chip logic and the `sg13g2_IOPadInOut4mA` ring. It applies masked writes, enforces a turnaround gap before any pad starts driving, synchronises pad inputs, and latches sticky pin-change flags with an interrupt. One command is in flight at a time; every accepted command produces exactly one response pulse.

## Interface
- `WIDTH`, 14: number of bidirectional pads controlled.
- `SYNC_STAGES`, 2: flops in each pad-input synchroniser; legal values are 2 or more.
- `TURN_CYCLES`, 2: idle cycles between releasing outputs and enabling new drivers; legal values are 1 or more.

- `clk` in 1: core clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: controller can accept; high only in IDLE.
- `cmd_op` in 2: 0 WRITE_OUT, 1 SET_DIR, 2 READ, 3 CLR_CHG.
- `cmd_mask` in WIDTH: per-pad select.
- `cmd_data` in WIDTH: per-pad value.
- `rsp_valid` out 1: one-cycle response strobe; no backpressure.
- `rsp_data` out WIDTH: response payload; valid only with `rsp_valid`.
- `pad_i` in WIDTH: asynchronous pad `p2c`.
- `pad_o` out WIDTH: pad `c2p`.
- `pad_oe` out WIDTH: pad `c2p_en`; 1 means drive.
- `chg_flags` out WIDTH: sticky input-change flags.
- `chg_irq` out 1: OR of `chg_flags`, registered.

## Operation
- FSM states: IDLE, EXEC, TURN, RESP.
- IDLE: `cmd_ready`=1. When `cmd_valid & cmd_ready`, latch op, mask and data, then go to EXEC.
- WRITE_OUT in EXEC: `pad_o <= (pad_o & ~mask) | (data & mask)`. Response is the new `pad_o`. Next state is RESP.
- SET_DIR in EXEC: release first with `pad_oe <= pad_oe & ~(mask & ~data)`.
  - `en_set = mask & data & ~pad_oe`.
  - If `en_set` is 0, go to RESP.
  - Otherwise load the turnaround counter with TURN_CYCLES-1 and go to TURN.
- TURN: decrement the counter. When it reaches 0, set `pad_oe <= pad_oe | en_set` and go to RESP. Response is the final `pad_oe`.
- Bits already enabled, or being released, never pass through TURN. Enabling never occurs in the same cycle as a release.
- READ in EXEC: capture the synchronised input vector. Response is that vector. Next state is RESP.
- CLR_CHG in EXEC: capture `chg_flags` as the response, then clear the flags selected by mask. If a change is detected on a bit in the same cycle as its clear, the set wins.
- RESP: `rsp_valid`=1 for exactly one cycle, then go to IDLE.
- Change detection: `chg_flags[i]` sets when synchronised input bit i differs from its previous-cycle value and `pad_oe[i]`=0.
  - Detection is suppressed for SYNC_STAGES+1 cycles after reset release; a warm-up counter handles this.
- `mask`=0 is legal: the command is a no-op write, but a response is still issued.

## Timing
- Reset values: `pad_o`=0, `pad_oe`=0 (all pads input), `chg_flags`=0, `chg_irq`=0, `rsp_valid`=0, `rsp_data`=0, synchronisers 0, state IDLE.
- `cmd_ready`=0 while `rst_n`=0. It rises the first cycle after reset release.
- Reset mid-command aborts the command: no response, and outputs return to reset values at the reset edge.
- Accept occurs at edge E0. EXEC applies at E1. `rsp_valid` is high in the cycle after E1.
- WRITE_OUT, READ and CLR_CHG: `pad_o`/flags update at E1, with `rsp_valid` from E1 to E2. Throughput is one command per 3 cycles.
- SET_DIR with enables: releases at E1, enables at E(1+TURN_CYCLES), `rsp_valid` during the following cycle.
- `pad_i` to synchronised value takes SYNC_STAGES edges. Flag update adds one edge; `chg_irq` adds one more.
- `cmd_valid` outside IDLE is ignored. The requester must hold it until it sees `cmd_ready`.

## Structure
- `pad_ctrl_pkg` holds:
  - the op encodings (`OP_WRITE_OUT`, `OP_SET_DIR`, `OP_READ`, `OP_CLR_CHG`);
  - the FSM state enum;
  - the default WIDTH, SYNC_STAGES and TURN_CYCLES.
- Sub-module `pad_sync`: a vector N-stage synchroniser (`clk`, `rst_n`, `d`, `q`), instantiated once, WIDTH bits wide.
- The FSM, registers and change detection live in the `pad_io_ctrl` body.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, drive `pad_i`=0x3FFF → all outputs 0, `cmd_ready`=0. After release, no flags set during warm-up, and `cmd_ready`=1 one cycle after release.
- WRITE_OUT mask=0x00FF data=0x0A5A starting from `pad_o`=0x3F00 → `pad_o`=0x3F5A at E1; `rsp_valid` for one cycle with `rsp_data`=0x3F5A.
- SET_DIR from `pad_oe`=0x000F, mask=0x00FF data=0x00F0, TURN_CYCLES=2 → `pad_oe`=0x0000 at E1 and 0x00F0 at E3. No cycle has both the old and new bits high. Response is 0x00F0.
- READ: `pad_i`=0x1234 held → `rsp_data`=0x1234. A `pad_i` change one cycle before accept is not seen (sync latency 2).
- Change and clear:
  - toggle `pad_i[3]` with `pad_oe[3]`=0 → `chg_flags`=0x0008, then `chg_irq`=1 one cycle later;
  - toggling `pad_i[5]` with `pad_oe[5]`=1 sets no flag;
  - CLR_CHG mask=0x0008 → response 0x0008, flags then 0;
  - a simultaneous toggle on bit 3 during the clear leaves the flag set.
- Reset asserted during TURN → no `rsp_valid`, `pad_oe`=0; the next command is accepted normally.
